cadc_serial_word_rx: RTL and testbench

Front-end receiver that deserializes the 20-bit serial data stream (sensor/bus words, LSB first) into parallel words. It presents each word with a sequenced 20-bit address to the processor's addr/data_in bus through a valid/ready handshake. It sits directly upstream of the microprocessor core and is the only writer of its input bus.

---
 rtl/cadc_pkg.sv | 16 +
 rtl/cadc_ser_shift.sv | 72 +++++++
 rtl/cadc_serial_word_rx.sv | 89 ++++++++
 tb/tb_cadc_serial_word_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cadc_pkg.sv
// Shared word/address widths, receiver FSM states and the core register-map
// addresses that the receiver's address sequence walks by default.
package cadc_pkg;
  localparam int WORD_W = 20;
  localparam int ADDR_W = 20;

  localparam int OPC   = 0;
  localparam int REGA  = 1;
  localparam int REGB  = 2;
  localparam int STORE = 3;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_e;
endpackage

// File: rtl/cadc_ser_shift.sv
// Serial-to-parallel framer: LSB-first bits on bit_en strobes, word_mark on bit 0.
// complete_o/framing_err_o are single-cycle pulses aligned with the sampling edge.
module cadc_ser_shift
  import cadc_pkg::*;
#(
  parameter int WORD_W = cadc_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en_i,
  input  logic              ser_in_i,
  input  logic              word_mark_i,
  output logic [WORD_W-1:0] word_o,
  output logic              complete_o,
  output logic              framing_err_o
);
  localparam int CNT_W = $clog2(WORD_W + 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // The top bit is never stored: it is taken straight from ser_in_i on completion.
  logic [WORD_W-2:0] shift_q, shift_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    complete_o    = 1'b0;
    framing_err_o = 1'b0;
    word_o        = {ser_in_i, shift_q};
    if (bit_en_i) begin
      unique case (state_q)
        RX_IDLE: begin
          if (word_mark_i) begin
            shift_d    = '0;
            shift_d[0] = ser_in_i;
            cnt_d      = CNT_W'(1);
            state_d    = RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (word_mark_i) begin
            // Early mark: drop the partial word and resync on this bit.
            framing_err_o = 1'b1;
            shift_d       = '0;
            shift_d[0]    = ser_in_i;
            cnt_d         = CNT_W'(1);
          end else if (cnt_q == CNT_W'(WORD_W - 1)) begin
            complete_o = 1'b1;
            cnt_d      = '0;
            state_d    = RX_IDLE;
          end else begin
            shift_d[cnt_q] = ser_in_i;
            cnt_d          = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/cadc_serial_word_rx.sv
// CADC serial word receiver: framer plus a one-word holding register presented
// on a valid/ready bus with a wrapping address sequence and sticky error flags.
module cadc_serial_word_rx
  import cadc_pkg::*;
#(
  parameter int                  WORD_W     = cadc_pkg::WORD_W,
  parameter int                  ADDR_W     = cadc_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]   BASE_ADDR  = ADDR_W'(OPC),
  parameter longint unsigned     ADDR_COUNT = longint'(STORE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en_i,
  input  logic              ser_in_i,
  input  logic              word_mark_i,
  input  logic              addr_clr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [WORD_W-1:0] out_data_o,
  output logic              overrun_o,
  output logic              framing_err_o
);
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(longint'(BASE_ADDR) + ADDR_COUNT - 64'd1);

  logic [WORD_W-1:0] rx_word;
  logic              rx_done, rx_ferr;

  cadc_ser_shift #(.WORD_W(WORD_W)) u_shift (
    .clk           (clk),
    .rst           (rst),
    .bit_en_i      (bit_en_i),
    .ser_in_i      (ser_in_i),
    .word_mark_i   (word_mark_i),
    .word_o        (rx_word),
    .complete_o    (rx_done),
    .framing_err_o (rx_ferr)
  );

  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovr_q, ovr_d;
  logic              ferr_q, ferr_d;
  logic              xfer, load;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= BASE_ADDR;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    xfer    = valid_q & out_ready_i;
    // The register frees up in the same cycle it is drained.
    load    = rx_done & (~valid_q | out_ready_i);
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    if (xfer) begin
      valid_d = 1'b0;
      addr_d  = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + ADDR_W'(1);
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = rx_word;
    end
    if (addr_clr_i) addr_d = BASE_ADDR;
    ovr_d  = ovr_q | (rx_done & valid_q & ~out_ready_i);
    ferr_d = ferr_q | rx_ferr;
  end

  assign out_valid_o   = valid_q;
  assign out_data_o    = data_q;
  assign out_addr_o    = addr_q;
  assign overrun_o     = ovr_q;
  assign framing_err_o = ferr_q;
endmodule

// File: tb/tb_cadc_serial_word_rx.sv
// Directed bench for cadc_serial_word_rx with a word-level reference model
// checked every cycle plus literal expectations per scenario.
module tb_cadc_serial_word_rx;
  localparam int W = 20;
  localparam int NADDR = 4;

  logic         clk = 1'b0;
  logic         rst, bit_en, ser_in, word_mark, addr_clr, out_ready;
  logic         out_valid, overrun, framing_err;
  logic [W-1:0] out_addr, out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cadc_serial_word_rx #(.BASE_ADDR(20'd0), .ADDR_COUNT(NADDR)) dut (
    .clk           (clk),
    .rst           (rst),
    .bit_en_i      (bit_en),
    .ser_in_i      (ser_in),
    .word_mark_i   (word_mark),
    .addr_clr_i    (addr_clr),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_addr_o    (out_addr),
    .out_data_o    (out_data),
    .overrun_o     (overrun),
    .framing_err_o (framing_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference model: bits collected into a frame counted from the last mark;
  // a full frame becomes a word offered to a one-deep holding slot.
  bit          started = 0;
  int          mcnt;
  int unsigned macc;
  bit          mvalid, mov, mfe;
  logic [W-1:0] mdata;
  int          mseq;
  bit          mdone, mxfer;
  logic [W-1:0] mword;

  always @(posedge clk) begin
    if (rst) begin
      started = 1; mcnt = 0; macc = 0; mvalid = 0; mdata = '0;
      mseq = 0; mov = 0; mfe = 0;
    end else if (started) begin
      mdone = 0;
      if (bit_en) begin
        if (word_mark) begin
          if (mcnt > 0) mfe = 1;
          mcnt = 1;
          macc = ser_in ? 1 : 0;
        end else if (mcnt > 0) begin
          macc += ser_in ? (32'd1 << mcnt) : 0;
          mcnt++;
          if (mcnt == W) begin
            mdone = 1;
            mword = W'(macc);
            mcnt  = 0;
          end
        end
      end
      mxfer = mvalid && out_ready;
      if (mxfer) begin
        mvalid = 0;
        mseq   = (mseq + 1) % NADDR;
      end
      if (mdone) begin
        if (mvalid) mov = 1;
        else begin
          mvalid = 1;
          mdata  = mword;
        end
      end
      if (addr_clr) mseq = 0;
    end
  end

  logic [W-1:0] cap_d[$], cap_a[$];

  always @(negedge clk) begin
    if (started) begin
      chk("valid", out_valid, mvalid);
      chk("data", out_data, mdata);
      chk("addr", out_addr, W'(mseq));
      chk("overrun", overrun, mov);
      chk("framing_err", framing_err, mfe);
      if (out_valid && out_ready) begin
        cap_d.push_back(out_data);
        cap_a.push_back(out_addr);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    cap_d.delete();
    cap_a.delete();
  endtask

  task automatic send_bit(input logic b, input logic mark);
    bit_en = 1'b1; ser_in = b; word_mark = mark;
    cyc();
    bit_en = 1'b0; ser_in = 1'b0; word_mark = 1'b0;
    cyc();
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) send_bit(w[i], i == 0);
  endtask

  task automatic chk_xfers(input string nm, input int n,
                           input logic [W-1:0] ed[5], input logic [W-1:0] ea[5]);
    chk({nm, "_count"}, cap_d.size(), n);
    for (int i = 0; i < n && i < cap_d.size(); i++) begin
      chk($sformatf("%s_data%0d", nm, i), cap_d[i], ed[i]);
      chk($sformatf("%s_addr%0d", nm, i), cap_a[i], ea[i]);
    end
  endtask

  initial begin
    logic [W-1:0] w;
    rst = 1'b1; bit_en = 1'b0; ser_in = 1'b0; word_mark = 1'b0;
    addr_clr = 1'b0; out_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_addr", out_addr, 20'd0);
    chk("rst_data", out_data, 20'd0);

    // Single word, latency of one clock after bit 19
    out_ready = 1'b1;
    w = 20'hA5A5A;
    for (int i = 0; i < W - 1; i++) send_bit(w[i], i == 0);
    chk("lat_pre_valid", out_valid, 1'b0);
    bit_en = 1'b1; ser_in = w[W-1];
    cyc();
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_data", out_data, 20'hA5A5A);
    chk("lat_addr", out_addr, 20'd0);
    bit_en = 1'b0; ser_in = 1'b0;
    cyc();
    chk("lat_drop", out_valid, 1'b0);

    // Five words, address wraps after four
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) send_word(W'(k));
    chk_xfers("seq", 5, '{20'd1, 20'd2, 20'd3, 20'd4, 20'd5},
                        '{20'd0, 20'd1, 20'd2, 20'd3, 20'd0});
    chk("seq_ovr", overrun, 1'b0);
    chk("seq_ferr", framing_err, 1'b0);

    // Overrun: second word dropped while first is held
    do_reset();
    out_ready = 1'b0;
    send_word(20'h11111);
    send_word(20'h22222);
    chk("ovr_data", out_data, 20'h11111);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    cyc();
    chk("ovr_after_valid", out_valid, 1'b0);
    chk_xfers("ovr", 1, '{20'h11111, 20'd0, 20'd0, 20'd0, 20'd0},
                        '{20'd0, 20'd0, 20'd0, 20'd0, 20'd0});

    // Framing error: mark at bit 7 begins the clean word
    do_reset();
    out_ready = 1'b1;
    w = 20'hFFFFF;
    for (int i = 0; i < 7; i++) send_bit(w[i], i == 0);
    send_word(20'h0F0F0);
    repeat (2) cyc();
    chk("fe_flag", framing_err, 1'b1);
    chk_xfers("fe", 1, '{20'h0F0F0, 20'd0, 20'd0, 20'd0, 20'd0},
                       '{20'd0, 20'd0, 20'd0, 20'd0, 20'd0});

    // Hunting without marks, then reset in the middle of a word
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 25; i++) send_bit(i[0], 1'b0);
    chk("hunt_valid", out_valid, 1'b0);
    w = 20'h3C3C3;
    for (int i = 0; i < 10; i++) send_bit(w[i], i == 0);
    rst = 1'b1; bit_en = 1'b1; ser_in = w[10];
    cyc();
    rst = 1'b0; bit_en = 1'b0; ser_in = 1'b0;
    cyc();
    for (int i = 11; i < W; i++) send_bit(w[i], 1'b0);
    repeat (2) cyc();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_xfers", cap_d.size(), 0);
    chk("midrst_ferr", framing_err, 1'b0);

    // addr_clr beats a simultaneous transfer increment; re-tags a held word
    do_reset();
    out_ready = 1'b1;
    send_word(20'h00AAA);
    send_word(20'h00BBB);
    out_ready = 1'b0;
    send_word(20'h00CCC);
    chk("clr_held_addr", out_addr, 20'd2);
    out_ready = 1'b1; addr_clr = 1'b1;
    cyc();
    addr_clr = 1'b0;
    chk("clr_addr", out_addr, 20'd0);
    chk("clr_valid", out_valid, 1'b0);
    send_word(20'h00DDD);
    out_ready = 1'b0;
    send_word(20'h00EEE);
    chk("retag_pre", out_addr, 20'd1);
    addr_clr = 1'b1;
    cyc();
    addr_clr = 1'b0;
    chk("retag_addr", out_addr, 20'd0);
    chk("retag_valid", out_valid, 1'b1);
    chk("retag_data", out_data, 20'h00EEE);
    chk_xfers("clr", 4, '{20'h00AAA, 20'h00BBB, 20'h00CCC, 20'h00DDD, 20'd0},
                        '{20'd0, 20'd1, 20'd2, 20'd0, 20'd0});

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
